// File: rtl/aplic_msi_forward_seq.sv
// MSI delivery sequencer: serves pending-and-enabled sources round-robin by identity.
// It issues one MSI request per selected source and strobes the gateway to clear that source's pending bit.
module aplic_msi_forward_seq #(
  parameter int numISources = 31,
  localparam int intrIdentW = $clog2(numISources + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [numISources:0]  intrsV,
  output logic                  msiReqValid,
  output logic [intrIdentW-1:0] msiReqIdent,
  input  logic                  msiReqReady,
  output logic                  clearPendValid,
  output logic [intrIdentW-1:0] clearPendIdent,
  output logic                  busy
);

  typedef enum logic [1:0] {SCAN, WRAP, REQ} state_t;

  state_t                  state_reg;
  logic [intrIdentW-1:0]   last_ident_reg;
  logic [intrIdentW-1:0]   req_ident_reg;

  logic [intrIdentW-1:0]   max_excluded;
  logic [numISources:1]    cand;
  logic [intrIdentW-1:0]   intr_ident;
  logic                    found;
  logic                    unused_bit0;

  // Identity 0 means "no source", so its pending bit never takes part in selection.
  assign unused_bit0  = intrsV[0];
  assign max_excluded = (state_reg == WRAP) ? '0 : last_ident_reg;

  generate
    for (genvar gi = 1; gi <= numISources; gi++) begin : g_cand
      localparam logic [intrIdentW-1:0] gi_ident = intrIdentW'(gi);
      assign cand[gi] = intrsV[gi] && (gi_ident > max_excluded);
    end
  endgenerate

  // The loop runs from the highest identity down, so the lowest eligible identity is written last and wins.
  always_comb begin
    intr_ident = '0;
    for (int i = numISources; i >= 1; i--) begin
      if (cand[i]) intr_ident = intrIdentW'(i);
    end
  end

  assign found = (intr_ident != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= SCAN;
      last_ident_reg <= '0;
      req_ident_reg  <= '0;
    end else begin
      case (state_reg)
        SCAN: begin
          if (enable) begin
            if (found) begin
              req_ident_reg <= intr_ident;
              state_reg     <= REQ;
            end else if (last_ident_reg != '0) begin
              state_reg <= WRAP;
            end
          end
        end
        WRAP: begin
          if (enable && found) begin
            req_ident_reg <= intr_ident;
            state_reg     <= REQ;
          end else begin
            last_ident_reg <= '0;
            state_reg      <= SCAN;
          end
        end
        REQ: begin
          // An accepted request is never withdrawn; only the handshake leaves this state.
          if (msiReqReady) begin
            last_ident_reg <= req_ident_reg;
            state_reg      <= SCAN;
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  assign msiReqValid    = (state_reg == REQ);
  assign msiReqIdent    = req_ident_reg;
  assign clearPendValid = (state_reg == REQ) && msiReqReady;
  assign clearPendIdent = (state_reg == REQ) ? req_ident_reg : '0;
  assign busy           = (state_reg != SCAN);

endmodule

// File: tb/tb_aplic_msi_forward_seq.sv
// Bench for aplic_msi_forward_seq: a scoreboard holds the expected MSI order and a simple gateway model clears pending bits.
module tb_aplic_msi_forward_seq;

  localparam int N = 31;
  localparam int W = $clog2(N + 1);

  logic         clock;
  logic         reset;
  logic         enable;
  logic [N:0]   pend;
  logic         msiReqValid;
  logic [W-1:0] msiReqIdent;
  logic         msiReqReady;
  logic         clearPendValid;
  logic [W-1:0] clearPendIdent;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int exp_q[$];
  int hs_q[$];

  logic         s_valid, s_cpv, s_busy;
  logic [W-1:0] s_ident, s_cpi;

  aplic_msi_forward_seq #(.numISources(N)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .intrsV         (pend),
    .msiReqValid    (msiReqValid),
    .msiReqIdent    (msiReqIdent),
    .msiReqReady    (msiReqReady),
    .clearPendValid (clearPendValid),
    .clearPendIdent (clearPendIdent),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // One clock cycle. Outputs are sampled at the falling edge, and a handshake is checked against the scoreboard.
  // A clear strobe is applied to the pending vector just after the rising edge.
  task automatic cyc();
    int clr;
    int e;
    clr = -1;
    @(negedge clock);
    s_valid = msiReqValid;
    s_ident = msiReqIdent;
    s_cpv   = clearPendValid;
    s_cpi   = clearPendIdent;
    s_busy  = busy;
    if (msiReqValid && msiReqReady) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ident %0d expected no request", msiReqIdent);
      end else begin
        e = exp_q.pop_front();
        if (int'(msiReqIdent) !== e) begin
          errors++;
          $display("FAIL sb_ident: got %0d expected %0d", msiReqIdent, e);
        end
      end
      hs_q.push_back(cyc_n);
      $display("msi ident=%0d cycle=%0d", msiReqIdent, cyc_n);
    end
    if (clearPendValid) clr = int'(clearPendIdent);
    @(posedge clock);
    #1;
    cyc_n++;
    if (clr >= 0) pend[clr] = 1'b0;
  endtask

  task automatic settle();
    pend = '0;
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; msiReqReady = 1'b0; pend = 32'h8;
    repeat (2) cyc();
    checks++;
    if ({s_valid, s_busy, s_cpv} !== 3'b000 || s_ident !== '0 || s_cpi !== '0) begin
      errors++;
      $display("FAIL reset_state: got v/b/c=%b%b%b id=%0d cid=%0d expected 000 0 0", s_valid, s_busy, s_cpv, s_ident, s_cpi);
    end
    reset = 1'b0; pend = '0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_%0d: got valid=%b busy=%b expected 0 0", i, s_valid, s_busy);
      end
    end
  endtask

  task automatic test_single();
    msiReqReady = 1'b1;
    pend[5] = 1'b1;
    exp_q.push_back(5);
    cyc();
    checks++;
    if (s_valid !== 1'b0) begin
      errors++; $display("FAIL single_first_cycle: got valid=%b expected 0", s_valid);
    end
    cyc();
    checks++;
    if (s_valid !== 1'b1 || s_ident !== 5'd5) begin
      errors++; $display("FAIL single_req: got valid=%b ident=%0d expected 1 5", s_valid, s_ident);
    end
    checks++;
    if (s_cpv !== 1'b1 || s_cpi !== 5'd5) begin
      errors++; $display("FAIL single_clear: got cpv=%b ident=%0d expected 1 5", s_cpv, s_cpi);
    end
    // A nonzero lastIdent with nothing pending produces one WRAP cycle.
    cyc();
    cyc();
    checks++;
    if (s_busy !== 1'b1) begin
      errors++; $display("FAIL single_wrap: got busy=%b expected 1", s_busy);
    end
    cyc();
    checks++;
    if (s_busy !== 1'b0) begin
      errors++; $display("FAIL single_back_scan: got busy=%b expected 0", s_busy);
    end
  endtask

  task automatic test_round_robin();
    settle();
    hs_q.delete();
    pend[3] = 1'b1; pend[7] = 1'b1; pend[12] = 1'b1;
    exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(12);
    for (int i = 0; i < 20 && hs_q.size() < 3; i++) cyc();
    checks++;
    if (hs_q.size() != 3) begin
      errors++; $display("FAIL rr_count: got %0d expected 3", hs_q.size());
    end else begin
      checks++;
      if (hs_q[1] - hs_q[0] != 2 || hs_q[2] - hs_q[1] != 2) begin
        errors++; $display("FAIL rr_spacing: got %0d,%0d expected 2,2", hs_q[1] - hs_q[0], hs_q[2] - hs_q[1]);
      end
    end
  endtask

  task automatic test_wrap();
    settle();
    hs_q.delete();
    pend[7] = 1'b1;
    exp_q.push_back(7);
    cyc();
    cyc();
    pend[2] = 1'b1; pend[5] = 1'b1;
    exp_q.push_back(2); exp_q.push_back(5);
    for (int i = 0; i < 20 && hs_q.size() < 3; i++) cyc();
    checks++;
    if (hs_q.size() != 3) begin
      errors++; $display("FAIL wrap_count: got %0d expected 3", hs_q.size());
    end else begin
      checks++;
      if (hs_q[1] - hs_q[0] != 3 || hs_q[2] - hs_q[1] != 2) begin
        errors++; $display("FAIL wrap_spacing: got %0d,%0d expected 3,2", hs_q[1] - hs_q[0], hs_q[2] - hs_q[1]);
      end
    end
  endtask

  task automatic test_boundary();
    settle();
    hs_q.delete();
    pend[31] = 1'b1;
    exp_q.push_back(31);
    for (int i = 0; i < 10 && hs_q.size() < 1; i++) cyc();
    // After identity 31 nothing can rank higher, so the next pick requires a wrap.
    pend[1] = 1'b1; pend[31] = 1'b1;
    exp_q.push_back(1); exp_q.push_back(31);
    for (int i = 0; i < 20 && hs_q.size() < 3; i++) cyc();
    checks++;
    if (hs_q.size() != 3) begin
      errors++; $display("FAIL bound_count: got %0d expected 3", hs_q.size());
    end else begin
      checks++;
      if (hs_q[1] - hs_q[0] != 3) begin
        errors++; $display("FAIL bound_spacing: got %0d expected 3", hs_q[1] - hs_q[0]);
      end
    end
  endtask

  task automatic test_hold();
    settle();
    msiReqReady = 1'b0;
    pend[9] = 1'b1;
    exp_q.push_back(9);
    cyc();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pend = $urandom();
      cyc();
      checks++;
      if (s_valid !== 1'b1 || s_ident !== 5'd9 || s_cpv !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: got valid=%b ident=%0d cpv=%b expected 1 9 0", i, s_valid, s_ident, s_cpv);
      end
    end
    msiReqReady = 1'b1;
    cyc();
    checks++;
    if (s_cpv !== 1'b1 || s_cpi !== 5'd9) begin
      errors++; $display("FAIL hold_release: got cpv=%b ident=%0d expected 1 9", s_cpv, s_cpi);
    end
    pend = 32'h0000_0108;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
        errors++; $display("FAIL disabled_%0d: got valid=%b busy=%b expected 0 0", i, s_valid, s_busy);
      end
    end
  endtask

  task automatic test_reset_mid_req();
    hs_q.delete();
    enable = 1'b1; msiReqReady = 1'b0;
    pend = '0; pend[4] = 1'b1; pend[20] = 1'b1;
    cyc();
    cyc();
    checks++;
    if (s_valid !== 1'b1 || s_ident !== 5'd20) begin
      errors++; $display("FAIL mid_req: got valid=%b ident=%0d expected 1 20", s_valid, s_ident);
    end
    #2;
    msiReqReady = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (msiReqValid !== 1'b0 || busy !== 1'b0 || clearPendValid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b busy=%b cpv=%b expected 0 0 0", msiReqValid, busy, clearPendValid);
    end
    repeat (2) cyc();
    checks++;
    if (s_cpv !== 1'b0 || pend[20] !== 1'b1) begin
      errors++; $display("FAIL reset_noclear: got cpv=%b pend20=%b expected 0 1", s_cpv, pend[20]);
    end
    reset = 1'b0;
    exp_q.push_back(4); exp_q.push_back(20);
    for (int i = 0; i < 20 && hs_q.size() < 2; i++) cyc();
    checks++;
    if (hs_q.size() != 2) begin
      errors++; $display("FAIL restart_count: got %0d expected 2", hs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_boundary();
    test_hold();
    test_reset_mid_req();
    settle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
